// File: rtl/led_bargraph_ctrl.sv
`default_nettype none
// ============================================================================
// led_bargraph_ctrl : sweeps an LED matrix, writing only the LEDs whose state changed
// Revision: 1.0
// ============================================================================
module led_bargraph_ctrl #(
   parameter int LEDS_N  = 2,
   parameter int LEDS_M  = 2,
   parameter int N_BITS  = 2,
   parameter int M_BITS  = 2,
   parameter int TIMEOUT = 1023,
   parameter int TO_BITS = 10
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_BITS+M_BITS:0]     level,
   input  logic                       level_stb,
   input  logic                       refresh,
   input  logic                       mx_done,
   output logic                       sel,
   output logic [N_BITS+M_BITS-1:0]   sel_addr,
   output logic                       en,
   output logic                       busy,
   output logic                       upd_done,
   output logic                       err
);
   localparam int NLEDS = LEDS_N * LEDS_M;
   localparam int AW    = N_BITS + M_BITS;
   localparam logic [AW:0]         NLEDS_V  = (AW+1)'(NLEDS);
   localparam logic [AW-1:0]       LAST_IDX = AW'(NLEDS - 1);
   localparam logic [TO_BITS-1:0]  TO_LAST  = TO_BITS'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      IDLE  = 3'd1,
      SCAN  = 3'd2,
      ISSUE = 3'd3,
      WAIT  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t              state, state_n;
   logic [AW:0]         target, target_n;
   logic [AW-1:0]       idx, idx_n;
   logic [NLEDS-1:0]    shadow, shadow_n;
   logic                force_wr, force_n;
   logic                pending, pending_n;
   logic [AW:0]         pend_level, pend_level_n;
   logic                pend_force, pend_force_n;
   logic [TO_BITS-1:0]  to_cnt, to_cnt_n;
   logic                err_q, err_n;
   logic                want, cur_shadow, advance;

   function automatic logic [AW:0] sat(input logic [AW:0] l);
      return (l > NLEDS_V) ? NLEDS_V : l;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= INIT;
         target     <= '0;
         idx        <= '0;
         shadow     <= '0;
         force_wr   <= 1'b0;
         pending    <= 1'b0;
         pend_level <= '0;
         pend_force <= 1'b0;
         to_cnt     <= '0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_n;
         target     <= target_n;
         idx        <= idx_n;
         shadow     <= shadow_n;
         force_wr   <= force_n;
         pending    <= pending_n;
         pend_level <= pend_level_n;
         pend_force <= pend_force_n;
         to_cnt     <= to_cnt_n;
         err_q      <= err_n;
      end
   end

   always_comb begin
      want       = ({1'b0, idx} < target);
      cur_shadow = 1'b0;
      for (int i = 0; i < NLEDS; i++) begin
         if (idx == AW'(i)) cur_shadow = shadow[i];
      end
   end

   always_comb begin
      state_n      = state;
      target_n     = target;
      idx_n        = idx;
      shadow_n     = shadow;
      force_n      = force_wr;
      pending_n    = pending;
      pend_level_n = pend_level;
      pend_force_n = pend_force;
      to_cnt_n     = to_cnt;
      err_n        = err_q;
      advance      = 1'b0;

      // Requests during a sweep are queued; a refresh alone reuses the current target
      if (state != IDLE && state != DONE) begin
         if (level_stb) begin
            pending_n    = 1'b1;
            pend_level_n = level;
         end else if (refresh && !pending) begin
            pend_level_n = target;
         end
         if (refresh) begin
            pending_n    = 1'b1;
            pend_force_n = 1'b1;
         end
      end

      case (state)
         INIT: begin
            target_n = '0;
            force_n  = 1'b1;
            idx_n    = '0;
            state_n  = SCAN;
         end
         IDLE: begin
            if (level_stb) begin
               target_n = sat(level);
               force_n  = refresh;
               idx_n    = '0;
               state_n  = SCAN;
            end else if (refresh) begin
               force_n  = 1'b1;
               idx_n    = '0;
               state_n  = SCAN;
            end
         end
         SCAN: begin
            if (force_wr || (want != cur_shadow)) state_n = ISSUE;
            else if (idx == LAST_IDX)             state_n = DONE;
            else                                  idx_n   = idx + AW'(1);
         end
         ISSUE: begin
            to_cnt_n = '0;
            state_n  = WAIT;
         end
         WAIT: begin
            if (mx_done) begin
               for (int i = 0; i < NLEDS; i++) begin
                  if (idx == AW'(i)) shadow_n[i] = want;
               end
               advance = 1'b1;
            end else if (to_cnt == TO_LAST) begin
               err_n   = 1'b1;
               advance = 1'b1;
            end else begin
               to_cnt_n = to_cnt + TO_BITS'(1);
            end
            if (advance) begin
               if (idx == LAST_IDX) begin
                  state_n = DONE;
               end else begin
                  idx_n   = idx + AW'(1);
                  state_n = SCAN;
               end
            end
         end
         DONE: begin
            force_n      = 1'b0;
            pending_n    = 1'b0;
            pend_force_n = 1'b0;
            // A strobe landing on the DONE cycle merges with any queued request
            if (pending || level_stb || refresh) begin
               target_n = sat(level_stb ? level : (pending ? pend_level : target));
               force_n  = (pending && pend_force) || refresh;
               idx_n    = '0;
               state_n  = SCAN;
            end else begin
               state_n  = IDLE;
            end
         end
         default: state_n = INIT;
      endcase
   end

   assign sel      = (state == ISSUE);
   assign sel_addr = idx;
   assign en       = ((state == ISSUE) || (state == WAIT)) && want;
   assign busy     = reset && (state != IDLE);
   assign upd_done = (state == DONE);
   assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_led_bargraph_ctrl.sv
`default_nettype none
// Scoreboard bench for led_bargraph_ctrl: expected matrix commands are queued by
// the stimulus and popped by a monitor on every sel pulse.
module tb_led_bargraph_ctrl;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [AW:0]   level = '0;
   logic          level_stb = 1'b0;
   logic          refresh = 1'b0;
   logic          mx_done = 1'b0;
   logic          sel, en, busy, upd_done, err;
   logic [AW-1:0] sel_addr;

   int tests = 0;
   int fails = 0;
   int upd_cnt = 0;
   int drop_addr = -1;
   logic [AW:0] exp_q[$];

   always #5 clk = ~clk;

   led_bargraph_ctrl #(
      .LEDS_N(2), .LEDS_M(2), .N_BITS(2), .M_BITS(2), .TIMEOUT(15), .TO_BITS(10)
   ) dut (
      .clk(clk), .reset(reset), .level(level), .level_stb(level_stb),
      .refresh(refresh), .mx_done(mx_done), .sel(sel), .sel_addr(sel_addr),
      .en(en), .busy(busy), .upd_done(upd_done), .err(err)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int addr, input int e);
      logic [AW:0] v;
      v = {AW'(addr), 1'(e)};
      exp_q.push_back(v);
   endtask

   task automatic strobe(input logic stb, input int lvl, input logic rf);
      level     = (AW+1)'(lvl);
      level_stb = stb;
      refresh   = rf;
      @(negedge clk);
      level_stb = 1'b0;
      refresh   = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy) return;
      end
      check({name, "_idle_timeout"}, 1, 0);
   endtask

   task automatic wait_sel(input string name, input int addr);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (sel && int'(sel_addr) == addr) return;
      end
      check({name, "_sel_timeout"}, 1, 0);
   endtask

   // Matrix model: ack 3 cycles after each sel unless the address is dropped
   initial begin
      int a;
      forever begin
         @(negedge clk);
         if (reset && sel) begin
            a = int'(sel_addr);
            repeat (3) @(negedge clk);
            if (reset && a != drop_addr) begin
               mx_done = 1'b1;
               @(negedge clk);
               mx_done = 1'b0;
            end
         end
      end
   end

   // Monitor
   initial begin
      logic prev_sel;
      logic [AW:0] e;
      prev_sel = 1'b0;
      forever begin
         @(negedge clk);
         if (reset && upd_done) upd_cnt++;
         if (reset && sel) begin
            check("sel_one_cycle", int'(prev_sel), 0);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_sel: got addr=%0d en=%0d expected no command", sel_addr, en);
            end else begin
               e = exp_q.pop_front();
               check("sel_addr", int'(sel_addr), int'(e[AW:1]));
               check("sel_en", int'(en), int'(e[0]));
            end
         end
         prev_sel = reset && sel;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int u0;
      int k;
      // Reset state and clearing sweep
      repeat (2) @(negedge clk);
      check("rst_sel", int'(sel), 0);
      check("rst_addr", int'(sel_addr), 0);
      check("rst_en", int'(en), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_upd", int'(upd_done), 0);
      check("rst_err", int'(err), 0);
      for (int i = 0; i < 4; i++) push(i, 0);
      u0 = upd_cnt;
      reset = 1'b1;
      wait_idle("init");
      check("init_q_empty", exp_q.size(), 0);
      check("init_upd", upd_cnt - u0, 1);
      check("init_err", int'(err), 0);

      // level 3, then level 1
      push(0, 1); push(1, 1); push(2, 1);
      strobe(1'b1, 3, 1'b0);
      wait_idle("lvl3");
      check("lvl3_q_empty", exp_q.size(), 0);
      push(1, 0); push(2, 0);
      u0 = upd_cnt;
      strobe(1'b1, 1, 1'b0);
      wait_idle("lvl1");
      check("lvl1_q_empty", exp_q.size(), 0);
      check("lvl1_upd", upd_cnt - u0, 1);

      // Saturation and no-change sweep timing
      push(1, 1); push(2, 1);
      strobe(1'b1, 3, 1'b0);
      wait_idle("lvl3b");
      push(3, 1);
      strobe(1'b1, 9, 1'b0);
      wait_idle("lvl9");
      check("lvl9_q_empty", exp_q.size(), 0);
      level = 5'd9;
      level_stb = 1'b1;
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         level_stb = 1'b0;
         if (upd_done) begin
            k = i;
            break;
         end
      end
      check("nochange_latency", k, 5);
      wait_idle("lvl9b");

      // Pending requests: last wins, one follow-up sweep
      push(2, 0); push(3, 0); push(2, 1); push(3, 1);
      u0 = upd_cnt;
      strobe(1'b1, 2, 1'b0);
      strobe(1'b1, 0, 1'b0);
      strobe(1'b1, 4, 1'b0);
      wait_idle("pend");
      check("pend_q_empty", exp_q.size(), 0);
      check("pend_upd", upd_cnt - u0, 2);

      // Dropped ack at addr 1
      drop_addr = 1;
      for (int i = 0; i < 4; i++) push(i, 0);
      strobe(1'b1, 0, 1'b0);
      wait_sel("drop", 1);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (i == 15) check("err_before_timeout", int'(err), 0);
         if (i == 16) check("err_at_timeout", int'(err), 1);
      end
      wait_idle("drop");
      check("drop_q_empty", exp_q.size(), 0);
      drop_addr = -1;
      push(1, 0);
      strobe(1'b1, 0, 1'b0);
      wait_idle("reissue");
      check("reissue_q_empty", exp_q.size(), 0);
      check("err_sticky", int'(err), 1);

      // Reset while in WAIT
      push(0, 1);
      strobe(1'b1, 4, 1'b0);
      wait_sel("midrst", 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_sel", int'(sel), 0);
      check("midrst_en", int'(en), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_err", int'(err), 0);
      check("midrst_addr", int'(sel_addr), 0);
      repeat (4) @(negedge clk);
      check("midrst_upd", int'(upd_done), 0);
      for (int i = 0; i < 4; i++) push(i, 0);
      reset = 1'b1;
      wait_idle("midrst");
      check("midrst_q_empty", exp_q.size(), 0);
      check("midrst_err_after", int'(err), 0);

      // Refresh alone, combined strobe, refresh queued during a sweep
      for (int i = 0; i < 4; i++) push(i, 0);
      strobe(1'b0, 0, 1'b1);
      wait_idle("refresh");
      check("refresh_q_empty", exp_q.size(), 0);
      push(0, 1); push(1, 1); push(2, 0); push(3, 0);
      push(0, 1); push(1, 1); push(2, 0); push(3, 0);
      u0 = upd_cnt;
      strobe(1'b1, 2, 1'b1);
      strobe(1'b0, 0, 1'b1);
      wait_idle("combo");
      check("combo_q_empty", exp_q.size(), 0);
      check("combo_upd", upd_cnt - u0, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/led_bargraph_ctrl.md
LED_BARGRAPH_CTRL -- requirements
Module: led_bargraph_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- LEDS_N, 2, matrix columns.
- LEDS_M, 2, matrix rows.
- N_BITS, 2, column address bits.
- M_BITS, 2, row address bits.
- TIMEOUT, 1023, max cycles to wait for matrix ack.
- TO_BITS, 10, timeout counter width.
REQ-002 SHALL derive NLEDS = LEDS_N*LEDS_M and AW = N_BITS+M_BITS.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- reset, in, 1, reset, asynchronous, active-low.
- level, in, AW+1, requested count of lit LEDs.
- level_stb, in, 1, one-cycle strobe qualifying level.
- refresh, in, 1, one-cycle strobe requesting a forced rewrite of all LEDs.
- mx_done, in, 1, per-command ack from the downstream LED matrix.
- sel, out, 1, one-cycle command strobe to the matrix.
- sel_addr, out, AW, LED linear index, zero-extended.
- en, out, 1, requested LED state.
- busy, out, 1, high in any state except IDLE.
- upd_done, out, 1, one-cycle pulse at the end of each sweep.
- err, out, 1, sticky ack-timeout flag.

Function
REQ-004 SHALL keep target (AW+1 bits), idx (AW bits), shadow[NLEDS] (last acknowledged LED states), force flag, pending flag plus pending level, and timeout counter.
REQ-005 SHALL saturate level: target = min(level, NLEDS); LED i is wanted on iff i < target.
REQ-006 SHALL implement states INIT, IDLE, SCAN, ISSUE, WAIT, DONE.
REQ-007 INIT: first cycle after reset release; target=0, force=1, idx=0; next state SCAN. This clears the whole matrix.
REQ-008 IDLE: on level_stb, latch target, force=refresh, idx=0, go to SCAN; on refresh alone, keep target, force=1, go to SCAN.
REQ-009 SCAN (one cycle per LED): if force or want != shadow[idx], go to ISSUE; else if idx==NLEDS-1, go to DONE; else idx+1 and stay in SCAN.
REQ-010 ISSUE: sel=1 for exactly one cycle with sel_addr=idx and en=want; clear the timeout counter; go to WAIT.
REQ-011 WAIT: sel=0, sel_addr and en held.
- On mx_done: shadow[idx]=want; go to DONE if idx==NLEDS-1, else idx+1 and SCAN.
- If no mx_done within TIMEOUT cycles: set err and advance exactly as if acked; shadow is not updated.
REQ-012 mx_done SHALL be ignored in every state except WAIT, including the ISSUE cycle.
REQ-013 DONE: upd_done=1 for one cycle, force=0. If pending, load pending level, clear pending, idx=0, go to SCAN; else go to IDLE.
REQ-014 level_stb while busy SHALL set pending and overwrite the pending level (last wins); refresh while busy SHALL set pending with a forced rewrite. The sweep in progress is not aborted.
REQ-015 Simultaneous level_stb and refresh SHALL be treated as one request with force=1.
REQ-016 A sweep with no changed LEDs and force=0 SHALL issue no sel and take NLEDS+1 cycles from leaving IDLE to upd_done.
REQ-017 At most one command SHALL be outstanding at any time.

Reset
REQ-018 While reset=0: sel=0, sel_addr=0, en=0, busy=0, upd_done=0, err=0, shadow all 0, pending=0, state=INIT.
REQ-019 Reset assertion mid-sweep SHALL abort immediately with no further sel; the INIT sweep runs again after release.
REQ-020 err SHALL clear only on reset.

Verification
Bench configuration: LEDS_N=LEDS_M=2, N_BITS=M_BITS=2, TIMEOUT=15. The matrix model asserts mx_done 3 cycles after sel unless stated otherwise.
REQ-021 Release reset -> four sel pulses, addr 0..3, en=0; one upd_done; busy drops; err=0.
REQ-022 level=3 strobe -> sel at addr 0,1,2 with en=1; no sel at addr 3; upd_done; then level=1 -> sel at addr 1,2 with en=0 only.
REQ-023 level=9 strobe -> saturates to 4 -> only addr 3 en=1 issued (shadow already 0,1,2 on); repeat level=9 -> zero sel, upd_done after 5 cycles.
REQ-024 level=2 then level=0 and level=4 strobed during the sweep -> first sweep completes; one follow-up sweep to target 4; no sweep to 0.
REQ-025 Model drops the ack for addr 1 -> err=1 after 15 cycles in WAIT; sweep continues to addr 3; a later level_stb re-issues addr 1.
REQ-026 Reset pulsed while in WAIT -> all outputs 0 within reset; full clear sweep after release; err=0.
